// File: rtl/adder_operand_loader_if.sv
// Byte-stream input and operand-frame output bundle for the adder operand loader.
interface adder_operand_loader_if #(
  parameter int DATA_W = 100,
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_cin;
  logic              out_valid;
  logic              out_ready;

  // Stream source plus frame consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_cin, out_valid
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_cin, out_valid
  );
endinterface

// File: rtl/adder_operand_loader.sv
// Assembles operand A, operand B and carry-in for the wide adder from a
// byte-serial stream, then holds the frame until the consumer takes it.
//
// state    | meaning
// LOAD_A   | collecting operand A bytes, LS byte first
// LOAD_B   | collecting operand B bytes, LS byte first
// LOAD_CIN | waiting for the single carry byte (bit 0 used)
// PRESENT  | frame complete, outputs frozen until out_ready
module adder_operand_loader #(
  parameter int DATA_W = 100,
  parameter int BYTE_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  adder_operand_loader_if.slave bus
);

  localparam int NBYTES = (DATA_W + BYTE_W - 1) / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_CIN, PRESENT} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              cin_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              accept;
  logic [SH_W-1:0]   shift;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] byte_val;
  logic [DATA_W-1:0] a_d, b_d;

  assign accept = bus.in_valid && in_ready_q;

  // Shifting the full-width byte up to its lane drops whatever spills past
  // the operand MSB, which is how the unused top nibble of the last byte
  // disappears.
  assign shift     = SH_W'(cnt_q) * SH_W'(BYTE_W);
  assign byte_mask = {{(DATA_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << shift;
  assign byte_val  = {{(DATA_W-BYTE_W){1'b0}}, bus.in_data} << shift;
  assign a_d       = (a_q & ~byte_mask) | byte_val;
  assign b_d       = (b_q & ~byte_mask) | byte_val;

  // Frame sequencing, byte placement and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            a_q <= a_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_q <= b_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_CIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        LOAD_CIN: begin
          if (accept) begin
            cin_q       <= bus.in_data[0];
            state_q     <= PRESENT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            cnt_q       <= '0;
            state_q     <= LOAD_A;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          cnt_q       <= '0;
          state_q     <= LOAD_A;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_cin   = cin_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for the adder operand loader with a frame-level reference model.
module tb_adder_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  adder_operand_loader_if bus ();

  adder_operand_loader dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_acc = 0;

  task automatic chk(input string name, input logic [99:0] got, input logic [99:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: bytes of the current frame collected in order; on the
  // 27th byte the operands are rebuilt by plain weighted sums.
  logic [7:0]  m_bytes [27];
  int          m_cnt = 0;
  bit          m_present = 0;
  logic [99:0] m_a = '0, m_b = '0;
  logic        m_cin = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      m_cnt = 0; m_present = 0; m_a = '0; m_b = '0; m_cin = 1'b0;
    end else if (m_present) begin
      if (bus.out_ready) begin
        m_present = 0;
        m_cnt = 0;
      end
    end else if (bus.in_valid) begin
      m_bytes[m_cnt] = bus.in_data;
      m_cnt++;
      if (m_cnt == 27) begin
        m_a = '0; m_b = '0;
        for (int k = 0; k < 13; k++) begin
          m_a = m_a | (100'(m_bytes[k]) << (8 * k));
          m_b = m_b | (100'(m_bytes[13 + k]) << (8 * k));
        end
        m_cin = m_bytes[26][0];
        m_present = 1;
      end
    end
  end

  // Acceptances as seen at the DUT boundary.
  always @(posedge clk) begin
    if (!rst && !flush && bus.in_valid && bus.in_ready) dut_acc++;
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 100'(bus.in_ready), 100'(!m_present));
      chk("out_valid", 100'(bus.out_valid), 100'(m_present));
      if (m_present && bus.out_valid) begin
        chk("out_a", bus.out_a, m_a);
        chk("out_b", bus.out_b, m_b);
        chk("out_cin", 100'(bus.out_cin), 100'(m_cin));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bubbles);
    int t = 0;
    @(negedge clk);
    if (bubbles && $urandom_range(1) == 1) begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
  endtask

  // Sends a whole frame; returns at the negedge after the carry byte is taken.
  task automatic send_frame(input logic [103:0] a, input logic [103:0] b,
                            input logic [7:0] c, input bit bubbles);
    for (int k = 0; k < 13; k++) send_byte(a[8*k +: 8], bubbles);
    for (int k = 0; k < 13; k++) send_byte(b[8*k +: 8], bubbles);
    send_byte(c, bubbles);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  logic [103:0] fa, fb;
  logic [99:0]  held_a;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;

    // 1: asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 100'(bus.out_valid), 100'd0);
    chk("rst_out_a", bus.out_a, 100'd0);
    chk("rst_out_b", bus.out_b, 100'd0);
    chk("rst_out_cin", 100'(bus.out_cin), 100'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 100'(bus.in_ready), 100'd1);
    end

    // 2: A=4999, B=1234, cin=1, consumer always ready
    send_frame(104'd4999, 104'd1234, 8'h01, 1'b0);
    chk("s2_valid", 100'(bus.out_valid), 100'd1);
    chk("s2_a", bus.out_a, 100'd4999);
    chk("s2_b", bus.out_b, 100'd1234);
    chk("s2_cin", 100'(bus.out_cin), 100'd1);
    @(negedge clk);
    chk("s2_in_ready_back", 100'(bus.in_ready), 100'd1);

    // 3: consumer stalls 5 cycles while the source keeps poking
    bus.out_ready = 1'b0;
    fa = 104'h00123456789ABCDEF0FEDCBA98;
    fb = 104'h00FEDCBA9876543210ABCDEF01;
    send_frame(fa, fb, 8'h03, 1'b0);
    held_a = fa[99:0];
    chk("s3_a", bus.out_a, held_a);
    dut_acc = 0;
    repeat (5) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_data = 8'($urandom);
      @(negedge clk);
      chk("s3_stall_ready", 100'(bus.in_ready), 100'd0);
      chk("s3_stall_a", bus.out_a, held_a);
    end
    chk("s3_no_consume", 100'(dut_acc), 100'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("s3_released_valid", 100'(bus.out_valid), 100'd0);
    chk("s3_released_ready", 100'(bus.in_ready), 100'd1);

    // 4: all-ones operands, carry byte FE
    send_frame({104{1'b1}}, {104{1'b1}}, 8'hFE, 1'b0);
    chk("s4_a", bus.out_a, {100{1'b1}});
    chk("s4_b", bus.out_b, {100{1'b1}});
    chk("s4_cin", 100'(bus.out_cin), 100'd0);

    // 5: scenario 2 with random bubbles
    @(negedge clk);
    dut_acc = 0;
    send_frame(104'd4999, 104'd1234, 8'h01, 1'b1);
    chk("s5_valid", 100'(bus.out_valid), 100'd1);
    chk("s5_a", bus.out_a, 100'd4999);
    chk("s5_b", bus.out_b, 100'd1234);
    chk("s5_cin", 100'(bus.out_cin), 100'd1);
    chk("s5_accepts", 100'(dut_acc), 100'd27);

    // 6: reset mid-frame, flush mid-frame, then a clean frame
    @(negedge clk);
    for (int k = 0; k < 10; k++) send_byte(8'(k + 1), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_a", bus.out_a, 100'd0);
    chk("s6_rst_valid", 100'(bus.out_valid), 100'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) send_byte(8'(k + 16), 1'b0);
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("s6_flush_a", bus.out_a, 100'd0);
    chk("s6_flush_b", bus.out_b, 100'd0);
    chk("s6_flush_valid", 100'(bus.out_valid), 100'd0);
    chk("s6_flush_ready", 100'(bus.in_ready), 100'd1);
    send_frame(104'd5, 104'd7, 8'h00, 1'b0);
    chk("s6_valid", 100'(bus.out_valid), 100'd1);
    chk("s6_a", bus.out_a, 100'd5);
    chk("s6_b", bus.out_b, 100'd7);
    chk("s6_cin", 100'(bus.out_cin), 100'd0);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
